// File: rtl/reg_dump_uart_if.sv
// Register-file debug read port: the dump unit presents an index and the
// register file answers combinationally in the same cycle.
interface reg_dump_uart_if;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (output rd_addr, input  rd_data);
  modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/reg_dump_uart.sv
// End-of-run register dump: on a rising edge of finish, sends 0xA5 followed by
// every register as four little-endian bytes over an 8N1 UART line.
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_REGS     = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           finish,
  reg_dump_uart_if.master dbg,
  output logic           uart_tx,
  output logic           busy,
  output logic           done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        LAST_REG = 5'(NUM_REGS - 1);
  localparam logic [7:0]        SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             finish_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_sel_q, byte_sel_d;
  logic             hdr_q, hdr_d;
  logic [4:0]       addr_q, addr_d;

  logic             bit_end;
  logic [1:0]       next_sel;

  assign bit_end  = (bit_cnt_q == CNT_MAX);
  assign next_sel = byte_sel_q + 2'd1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    byte_sel_d = byte_sel_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (finish && !finish_q) begin
          state_d    = START;
          shift_d    = SYNC;
          addr_d     = '0;
          hdr_d      = 1'b1;
          byte_sel_d = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = LOAD;
          end else if (byte_sel_q != 2'd3) begin
            byte_sel_d = next_sel;
            shift_d    = word_q[{next_sel, 3'b000} +: 8];
            state_d    = START;
          end else if (addr_q < LAST_REG) begin
            addr_d  = addr_q + 5'd1;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // The extra idle-high cycle gives the read port a full cycle on a
        // stable address before its data is captured.
        bit_cnt_d  = '0;
        word_d     = dbg.rd_data;
        shift_d    = dbg.rd_data[7:0];
        byte_sel_d = '0;
        state_d    = START;
      end
      DONE: begin
        bit_cnt_d = '0;
        if (!finish) state_d = IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      finish_q   <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      byte_sel_q <= '0;
      hdr_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      finish_q   <= finish;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      byte_sel_q <= byte_sel_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
    end
  end

  assign dbg.rd_addr = addr_q;

  // Outputs decode straight from registered state, so the start bit appears
  // on the same edge that accepts the trigger.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign busy = (state_q == START) || (state_q == DATA) ||
                (state_q == STOP)  || (state_q == LOAD);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: directed dumps, with a UART-decoding monitor that
// checks every received byte against a queue of expected bytes.
module tb_reg_dump_uart;

  localparam int CPB         = 4;
  localparam int NUM_REGS    = 32;
  localparam int DUMP_CYCLES = (1 + 4 * NUM_REGS) * 10 * CPB + NUM_REGS;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic finish = 1'b0;
  wire  uart_tx, busy, done;

  reg_dump_uart_if dbg ();

  logic [31:0] regs [NUM_REGS];
  assign dbg.rd_data = regs[dbg.rd_addr];

  reg_dump_uart #(
    .CLKS_PER_BIT (CPB),
    .NUM_REGS     (NUM_REGS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .finish  (finish),
    .dbg     (dbg),
    .uart_tx (uart_tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q [$];
  bit         mon_en   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_dump();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NUM_REGS; i++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(regs[i][8*b +: 8]);
  endtask

  task automatic wait_done(output int t);
    int budget;
    budget = 0;
    while (done !== 1'b1 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      $display("FAIL done_timeout: done never rose within %0d cycles", budget);
    end
    t = cyc;
  endtask

  // Monitor: captures 40 samples per frame and checks framing, bit widths
  // and the byte value against the head of the expected queue.
  initial begin
    logic [39:0] s;
    logic [9:0]  bits;
    logic [3:0]  grp;
    logic        frame_ok;
    logic [7:0]  e;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        s       = '0;
        s[0]    = uart_tx;
        aborted = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (!mon_en) begin
            aborted = 1'b1;
            break;
          end
          s[k] = uart_tx;
        end
        if (!aborted) begin
          frame_ok = 1'b1;
          for (int j = 0; j < 10; j++) begin
            grp = s[4*j +: 4];
            if (grp !== {4{grp[0]}}) frame_ok = 1'b0;
            bits[j] = grp[0];
          end
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_ok = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %0h with no byte expected", bits[8:1]);
          end else begin
            e = exp_q.pop_front();
            check("uart_byte{frame_ok,data}", {frame_ok, bits[8:1]}, {1'b1, e});
          end
        end
      end
    end
  end

  initial begin
    int          t0, t_done, bad;
    logic [9:0]  hdr_bits;
    logic [3:0]  grp;

    hdr_bits = 10'b1101001010;  // start, 0xA5 LSB first, stop; bit 0 sent first
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h11223300 + i;

    // Reset held with finish high, then trigger on the first edge after release.
    rst    = 1'b1;
    finish = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    push_dump();
    rst = 1'b0;
    @(negedge clk);
    t0 = cyc;
    check("trigger_uart_tx", uart_tx, 1'b0);
    check("trigger_busy", busy, 1'b1);
    wait_done(t_done);
    check("dump_length", t_done - t0, DUMP_CYCLES);

    // finish stays high: no retrigger, done holds.
    bad = 0;
    while (cyc - t0 < 10000) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("level_done_held_errors", bad, 0);
    finish = 1'b0;
    @(negedge clk);
    check("level_done_clear", done, 1'b0);
    check("level_no_missing_bytes", exp_q.size(), 0);

    // Second pulse with the same register file: identical dump, header bit timing.
    push_dump();
    finish = 1'b1;
    @(negedge clk);
    t0     = cyc;
    finish = 1'b0;
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (j != 0 || k != 0) @(negedge clk);
        grp[k] = uart_tx;
      end
      check($sformatf("hdr_bit%0d", j), grp, {4{hdr_bits[j]}});
    end
    wait_done(t_done);
    check("pulse_dump_length", t_done - t0, DUMP_CYCLES);
    @(negedge clk);
    check("pulse_done_clear", done, 1'b0);
    check("pulse_no_missing_bytes", exp_q.size(), 0);

    // Glitch on finish mid-dump must not disturb the stream.
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hC0DE0000 ^ (i * 32'h01030507);
    push_dump();
    finish = 1'b1;
    @(negedge clk);
    t0 = cyc;
    while (cyc - t0 < 1000) @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    finish = 1'b1;
    wait_done(t_done);
    check("glitch_dump_length", t_done - t0, DUMP_CYCLES);
    finish = 1'b0;
    @(negedge clk);
    check("glitch_done_clear", done, 1'b0);
    check("glitch_no_missing_bytes", exp_q.size(), 0);

    // Reset in the middle of a dump, then a clean restart from the header.
    mon_en = 1'b0;
    finish = 1'b1;
    @(negedge clk);
    t0     = cyc;
    finish = 1'b0;
    while (cyc - t0 < 300) @(negedge clk);
    check("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_uart_tx", uart_tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rd_addr", dbg.rd_addr, 5'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_idle_after_rst", {busy, done, uart_tx}, 3'b001);
    mon_en = 1'b1;
    push_dump();
    finish = 1'b1;
    @(negedge clk);
    t0     = cyc;
    finish = 1'b0;
    check("restart_uart_tx", uart_tx, 1'b0);
    wait_done(t_done);
    check("restart_dump_length", t_done - t0, DUMP_CYCLES);
    repeat (2) @(negedge clk);
    check("restart_no_missing_bytes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_uart.md
# reg_dump_uart

End-of-run register-file dump unit for the Quinta core. On a rising edge of `finish`, the block walks all architectural registers through the register file's debug read port. It transmits a 0xA5 sync byte followed by every register as four little-endian bytes on a single 8N1 UART line. It is the responder to the `finish` request that the bench and top-level drive, so register state can be captured on hardware without a waveform dump.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `NUM_REGS`, default 32: number of registers dumped, indices 0..NUM_REGS-1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `finish` input, 1 bit: dump request; only its rising edge is acted on.
- `rd_addr` output, 5 bits: register index presented to the register-file debug read port.
- `rd_data` input, 32 bits: combinational read data for `rd_addr`.
- `uart_tx` output, 1 bit: serial output, idle high.
- `busy` output, 1 bit: high while a dump is in progress.
- `done` output, 1 bit: high after a dump completes, until `finish` falls.

## Operation
- The block registers `finish` into `finish_q` every cycle. A trigger occurs when `finish & ~finish_q` in IDLE. Edges seen in any other state are ignored.
- States and transitions:
  - IDLE → START: on trigger. The shift byte is loaded with 0xA5, `rd_addr` = 0, and `hdr` = 1.
  - START: drives a 0 for one bit time, then → DATA.
  - DATA: drives 8 bits, LSB first, one bit time each, then → STOP.
  - STOP: drives a 1 for one bit time. The next state then depends on the byte just sent:
    - Header byte: → LOAD.
    - Byte 0..2 of a word: the next word byte goes into the shift byte, then → START.
    - Byte 3 of a word with `rd_addr` < NUM_REGS-1: `rd_addr`++ and → LOAD.
    - Byte 3 of the last word: → DONE.
  - LOAD: one cycle. Latches `rd_data` into the 32-bit word register and loads byte 0 (`word[7:0]`), then → START.
  - DONE: `uart_tx` = 1 and `done` = 1. → IDLE when `finish` = 0.
- Byte order per word: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- Register x0 is dumped as read; the block does not force it to zero.
- A bit-period counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. A bit-index counter counts 0..7 in DATA.
- `busy` = 1 in START, DATA, STOP and LOAD, otherwise 0. `busy` and `done` are never both 1.

## Timing
- Reset values: `uart_tx` = 1, `busy` = 0, `done` = 0, `rd_addr` = 0, state IDLE, `finish_q` = 0, all counters 0.
- Trigger latency: on the clock edge at which `finish` is first sampled high, `uart_tx` goes 0 and `busy` goes 1. That is zero added cycles after the edge.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - A byte occupies 10·CLKS_PER_BIT cycles.
  - There is no gap between bytes of the same word, or between the header and the LOAD.
- Each LOAD inserts exactly one extra idle-high cycle before a word's byte 0.
- `rd_addr` is stable for the whole LOAD cycle and changes only on the STOP→LOAD edge.
- Total dump length from trigger to `done` rising: (1 + 4·NUM_REGS)·10·CLKS_PER_BIT + NUM_REGS cycles. With defaults and CLKS_PER_BIT = 4, this is 5192 cycles.
- `finish` held high through the whole dump: no retrigger occurs. `done` stays 1 until `finish` = 0, then the block returns to IDLE on the next edge and is rearmed.
- `finish` toggling during a dump is ignored. A 0→1 transition while in DONE does not retrigger; the block must pass through IDLE first.
- `rst` mid-dump: on the next edge every output returns to its reset value and the block goes to IDLE. A `finish` already high at reset release triggers on the first edge after `rst` falls.

## Test plan
- Reset check: hold `rst` for 2 cycles with `finish` = 1 → `uart_tx` = 1, `busy` = 0, `done` = 0 during reset. After release, a trigger occurs on the first edge and `uart_tx` = 0.
- Header framing (CLKS_PER_BIT = 4): pulse `finish` → decoded bits are 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop), each exactly 4 cycles wide.
- Full dump: register file preloaded with reg[i] = 0x11223300 + i → the bench UART decoder receives 129 bytes, beginning A5, 00 33 22 11, 01 33 22 11, … and ending 1F 33 22 11. `done` rises at cycle 5192 after the trigger.
- Level finish: hold `finish` = 1 for 10000 cycles → exactly one dump, and `done` stays 1 until `finish` falls. A second pulse then produces a second identical dump.
- Mid-dump reset: assert `rst` at cycle 300 of a dump → the next cycle shows `uart_tx` = 1 and `busy` = 0. A new `finish` edge restarts from the 0xA5 header.
- Glitch immunity: toggle `finish` 1→0→1 at cycle 1000 of a dump → the byte stream is unchanged, with no restart and no extra bytes.
